// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised integer register file for the pipelined core.
//   - 2 asynchronous read ports, 1 synchronous write port
//   - optional hard-zero entry 0 (ZERO_REG)
//   - hardware zero-sweep after reset or on CLR, reported on BUSY
//   - per-entry pending scoreboard for RAW hazard detection at decode
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data (and the matching pending state) onto the read ports.
//
// Handshake note: there is no valid/ready flow control here. EN, RSV_EN and
// CLR are single-cycle qualifiers sampled at posedge CLK; EN/RSV_EN are
// accepted only while BUSY=0, CLR only while BUSY=0, and nothing stalls.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] ADR1,
    input  logic [ADDR_W-1:0] ADR2,
    output logic [DATA_W-1:0] RS1,
    output logic [DATA_W-1:0] RS2,
    input  logic              RSV_EN,
    input  logic [ADDR_W-1:0] RSV_ADR,
    output logic              PEND1,
    output logic              PEND2,
    input  logic              CLR,
    output logic              BUSY
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_SWEEP = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              idle;
    logic              wr_ok;
    logic              rsv_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [DATA_W-1:0] ram_wd;

    // Entry 0 is read-only and never pending when ZERO_REG is set.
    assign idle   = (state_q == S_IDLE);
    assign wr_ok  = idle && EN     && !((ZERO_REG != 0) && (WA == '0));
    assign rsv_ok = idle && RSV_EN && !((ZERO_REG != 0) && (RSV_ADR == '0));
    assign BUSY   = !idle;

    // Sequencer: reset or CLR starts a sweep from entry 0; the sweep visits
    // every entry once and then hands control back to normal operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_SWEEP;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_SWEEP: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (CLR) begin
                        state_q <= S_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_SWEEP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Single array write port shared by reset, sweep and normal writes.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = WA;
        ram_wd = WD;
        if (RST) begin
            ram_we = 1'b1;
            ram_wa = '0;
            ram_wd = '0;
        end else if (!idle) begin
            ram_we = 1'b1;
            ram_wa = cnt_q;
            ram_wd = '0;
        end else if (wr_ok) begin
            ram_we = 1'b1;
        end
    end

    // Register array storage.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[ram_wa] <= ram_wd;
        end
    end

    // Scoreboard next state: a reserve applied after the write so that a
    // same-cycle reserve (younger instruction) keeps the entry pending.
    always_comb begin
        pend_d = pend_q;
        if (RST || (idle && CLR)) begin
            pend_d = '0;
        end else begin
            if (wr_ok) begin
                pend_d[WA] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[RSV_ADR] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge CLK) begin
        pend_q <= pend_d;
    end

    // Read port 1: zero while sweeping, hard zero on entry 0, optional bypass.
    always_comb begin
        RS1   = ram_q[ADR1];
        PEND1 = pend_q[ADR1];
        if ((ZERO_REG != 0) && (ADR1 == '0)) begin
            RS1   = '0;
            PEND1 = 1'b0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (WA == ADR1)) begin
            RS1   = WD;
            PEND1 = rsv_ok && (RSV_ADR == ADR1);
        end
`endif
        if (!idle) begin
            RS1   = '0;
            PEND1 = 1'b0;
        end
    end

    // Read port 2: identical structure to port 1.
    always_comb begin
        RS2   = ram_q[ADR2];
        PEND2 = pend_q[ADR2];
        if ((ZERO_REG != 0) && (ADR2 == '0)) begin
            RS2   = '0;
            PEND2 = 1'b0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (WA == ADR2)) begin
            RS2   = WD;
            PEND2 = rsv_ok && (RSV_ADR == ADR2);
        end
`endif
        if (!idle) begin
            RS2   = '0;
            PEND2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb (DATA_W=32, ADDR_W=5,
// ZERO_REG=1). Expected values are hand-computed constants.
module tb_reg_file_sb;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [4:0]  ADR1;
    logic [4:0]  ADR2;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic        RSV_EN;
    logic [4:0]  RSV_ADR;
    logic        PEND1;
    logic        PEND2;
    logic        CLR;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int edges;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep1;
        logic        ep2;
    } vec_t;

    vec_t vecs [17];

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .WA(WA), .WD(WD),
        .ADR1(ADR1), .ADR2(ADR2), .RS1(RS1), .RS2(RS2),
        .RSV_EN(RSV_EN), .RSV_ADR(RSV_ADR), .PEND1(PEND1), .PEND2(PEND2),
        .CLR(CLR), .BUSY(BUSY)
    );

    // clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // advance one edge; inputs are then driven at posedge+1
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        EN = 1'b0; WA = '0; WD = '0;
        RSV_EN = 1'b0; RSV_ADR = '0; CLR = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        EN = 1'b1; WA = a; WD = d;
        tick();
        EN = 1'b0;
    endtask

    // count edges until BUSY drops, bounded
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            n = k;
            if (!BUSY) break;
        end
    endtask

    // all entries zero and not pending
    task automatic check_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            ADR1 = 5'(a);
            ADR2 = 5'(31 - a);
            #1;
            check({name, " rs1"}, RS1, 32'h0);
            check({name, " rs2"}, RS2, 32'h0);
            check({name, " pend1"}, 32'(PEND1), 32'h0);
            check({name, " pend2"}, 32'(PEND2), 32'h0);
        end
    endtask

    initial begin
        //              en    wa     wd            rsv   ra     a1     a2     e1            e2            p1    p2
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd3,  5'd4,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1};
        vecs[6]  = '{1'b1, 5'd8,  32'h11111111, 1'b0, 5'd0,  5'd7,  5'd8,  32'h0,        32'h0,        1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd7,  32'hCAFEF00D, 1'b0, 5'd0,  5'd8,  5'd6,  32'h11111111, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd3,  32'h00000003, 1'b1, 5'd0,  5'd7,  5'd0,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h00000003, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'd7,  32'h0BADC0DE, 1'b1, 5'd7,  5'd3,  5'd5,  32'h00000003, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h0BADC0DE, 32'h0BADC0DE, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 5'd7,  32'h77777777, 1'b0, 5'd0,  5'd5,  5'd3,  32'hDEADBEEF, 32'h00000003, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd8,  32'h77777777, 32'h11111111, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 5'd10, 32'hAAAA0010, 1'b1, 5'd9,  5'd5,  5'd3,  32'hDEADBEEF, 32'h00000003, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd10, 32'h0,        32'hAAAA0010, 1'b1, 1'b0};

        // ---- reset sweep ----
        RST = 1'b1;
        drive_idle();
        ADR1 = 5'd5;
        ADR2 = 5'd9;
        repeat (3) tick();
        check("busy in reset", 32'(BUSY), 32'h1);
        check("rs1 in reset", RS1, 32'h0);
        check("pend1 in reset", 32'(PEND1), 32'h0);
        RST = 1'b0;
        // requests during the sweep must be dropped
        EN = 1'b1; WA = 5'd5; WD = 32'h5555AAAA;
        RSV_EN = 1'b1; RSV_ADR = 5'd6;
        count_busy(edges);
        drive_idle();
        check("reset busy edges", 32'(edges), 32'd32);
        check_all_zero("post reset");

        // ---- table vectors ----
        for (int i = 0; i < 17; i++) begin
            EN = vecs[i].en; WA = vecs[i].wa; WD = vecs[i].wd;
            RSV_EN = vecs[i].rsv; RSV_ADR = vecs[i].ra;
            ADR1 = vecs[i].a1; ADR2 = vecs[i].a2;
            #1;
            check($sformatf("vec%0d rs1", i), RS1, vecs[i].e1);
            check($sformatf("vec%0d rs2", i), RS2, vecs[i].e2);
            check($sformatf("vec%0d pend1", i), 32'(PEND1), 32'(vecs[i].ep1));
            check($sformatf("vec%0d pend2", i), 32'(PEND2), 32'(vecs[i].ep2));
            tick();
        end
        drive_idle();

        // ---- same-cycle write/read on x9 (pending from vec15) ----
        EN = 1'b1; WA = 5'd9; WD = 32'hA5A5A5A5;
        ADR1 = 5'd5; ADR2 = 5'd9;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("bypass rs2", RS2, 32'hA5A5A5A5);
        check("bypass pend2", 32'(PEND2), 32'h0);
`else
        check("no bypass rs2", RS2, 32'h0);
        check("no bypass pend2", 32'(PEND2), 32'h1);
`endif
        tick();
        EN = 1'b0;
        #1;
        check("after write rs2", RS2, 32'hA5A5A5A5);
        check("after write pend2", 32'(PEND2), 32'h0);
        EN = 1'b1; WA = 5'd9; WD = 32'h5A5A5A5A;
        RSV_EN = 1'b1; RSV_ADR = 5'd9; ADR1 = 5'd9;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("bypass rsv rs1", RS1, 32'h5A5A5A5A);
        check("bypass rsv pend1", 32'(PEND1), 32'h1);
`else
        check("no bypass rsv rs1", RS1, 32'hA5A5A5A5);
        check("no bypass rsv pend1", 32'(PEND1), 32'h0);
`endif
        tick();
        drive_idle();
        #1;
        check("rsv+wr rs1", RS1, 32'h5A5A5A5A);
        check("rsv+wr pend1", 32'(PEND1), 32'h1);

        // ---- fill x1..x31 and read back through the scoreboard ----
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'hF000_0000 | (32'(i) << 8) | 32'(i));
            exp_q.push_back(32'hF000_0000 | (32'(i) << 8) | 32'(i));
        end
        RSV_EN = 1'b1; RSV_ADR = 5'd4;
        tick();
        RSV_EN = 1'b0;
        for (int i = 1; i < 32; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            ADR1 = 5'(i);
            ADR2 = 5'(i);
            #1;
            check($sformatf("fill x%0d rs1", i), RS1, e);
            check($sformatf("fill x%0d rs2", i), RS2, e);
        end
        ADR1 = 5'd4;
        #1;
        check("x4 pending before clr", 32'(PEND1), 32'h1);

        // ---- CLR sweep; CLR held for a few edges (ignored while busy) ----
        CLR = 1'b1;
        tick();
        check("busy after clr", 32'(BUSY), 32'h1);
        EN = 1'b1; WA = 5'd31; WD = 32'hFFFFFFFF;
        RSV_EN = 1'b1; RSV_ADR = 5'd31;
        ADR1 = 5'd31; ADR2 = 5'd1;
        #1;
        check("rs1 zero while busy", RS1, 32'h0);
        check("rs2 zero while busy", RS2, 32'h0);
        check("pend1 zero while busy", 32'(PEND1), 32'h0);
        edges = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            edges = k;
            if (k == 5) CLR = 1'b0;
            if (!BUSY) break;
        end
        drive_idle();
        check("clr busy edges", 32'(edges), 32'd32);
        check_all_zero("post clr");

        // ---- reset asserted mid-sweep at cnt=10 ----
        write_reg(5'd20, 32'h20202020);
        ADR1 = 5'd20;
        #1;
        check("x20 written", RS1, 32'h20202020);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        repeat (2) tick();
        check("busy in mid reset", 32'(BUSY), 32'h1);
        RST = 1'b0;
        count_busy(edges);
        check("mid reset busy edges", 32'(edges), 32'd32);
        ADR1 = 5'd20;
        ADR2 = 5'd5;
        #1;
        check("x20 swept", RS1, 32'h0);
        check("x5 swept", RS2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the OTTER integer register file, sized for the pipelined core.
- Provides 2 asynchronous read ports and 1 synchronous write port, with configurable width/depth and optional hard-zero entry 0.
- Adds a hardware clear sequencer (zero-sweep after reset or on request) and a per-entry pending scoreboard, so decode can detect RAW hazards against in-flight writebacks.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and never goes pending; 0 = entry 0 is an ordinary register.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  write enable.
- WA  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- ADR1  in  ADDR_W  read address, port 1.
- ADR2  in  ADDR_W  read address, port 2.
- RS1  out  DATA_W  read data, port 1.
- RS2  out  DATA_W  read data, port 2.
- RSV_EN  in  1  reserve request: mark RSV_ADR pending.
- RSV_ADR  in  ADDR_W  address to reserve.
- PEND1  out  1  pending bit for ADR1.
- PEND2  out  1  pending bit for ADR2.
- CLR  in  1  start a zero-sweep of all entries.
- BUSY  out  1  sweep in progress.

Behaviour:
- States:
  - SWEEP: counter cnt (ADDR_W bits) walks through the array.
  - IDLE: normal operation.
- Reset (posedge with RST=1): state=SWEEP, cnt=0, all pending bits cleared, entry 0 written 0.
  - Holding RST keeps cnt=0.
  - RST asserted mid-sweep restarts at cnt=0.
- SWEEP, RST=0, each posedge:
  - ram[cnt] <= 0.
  - If cnt==DEPTH-1, go to IDLE; else cnt++.
  - BUSY stays high for exactly DEPTH posedges after the first cycle with RST=0, then drops.
- CLR=1 at a posedge in IDLE: enter SWEEP with cnt=0 and clear all pending bits. CLR is ignored while BUSY.
- No initial-block preload; array contents are defined only after the first completed sweep.
- Outputs while BUSY=1 (including during RST):
  - RS1=RS2=0, PEND1=PEND2=0.
  - EN and RSV_EN are ignored (no array or scoreboard change).
- Reads (IDLE): asynchronous; RSx = ram[ADRx].
  - With ZERO_REG=1 and ADRx==0, RSx=0 regardless of array content.
- Write (IDLE, posedge, EN=1): ram[WA] <= WD and pend[WA] <= 0.
  - Write dropped when ZERO_REG=1 and WA==0.
- Reserve (IDLE, posedge, RSV_EN=1): pend[RSV_ADR] <= 1.
  - Dropped when ZERO_REG=1 and RSV_ADR==0.
- Reserve and write to the same address in the same cycle: reserve wins, so pend=1 and data is still written (the younger instruction owns the register).
- PENDx = pend[ADRx], combinational. pend[0]=0 always when ZERO_REG=1.
- Both read ports may address the same entry; each returns identical data.
- Width rules:
  - All addresses are used modulo DEPTH; no out-of-range case exists.
  - WD is stored unmodified at DATA_W bits.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined (IDLE only): if EN=1, WA==ADRx and the write is not dropped, then:
  - RSx = WD in the same cycle (write-through forwarding).
  - PENDx = 0, unless RSV_EN=1 with RSV_ADR==ADRx in that cycle, in which case PENDx = 1.
- Undefined: RSx and PENDx reflect stored state only; the new value is visible from the cycle after the write edge.

Test Plan:
- Reset sweep, DEPTH=32: RST high 3 cycles, then low.
  - Required: BUSY=1 for exactly 32 posedges after RST falls, then 0.
  - Required: all 32 entries read 0 afterwards, and PEND1=PEND2=0.
- Basic write/read: write x5=0xDEADBEEF, then ADR1=5, ADR2=5.
  - Required: RS1=RS2=0xDEADBEEF on the cycle after the write edge.
  - Write x0=0x12345678 (ZERO_REG=1), then ADR1=0: required RS1=0.
- Scoreboard: reserve x7, then ADR1=7.
  - Required: PEND1=1 until the EN=1, WA=7 edge, then 0.
  - Reserve and write x7 in the same cycle: required PEND1=1 afterwards and data updated.
- Bypass:
  - Macro defined: EN=1, WA=9, WD=0xA5A5A5A5, ADR2=9 in the same cycle → RS2=0xA5A5A5A5 before the edge.
  - Macro undefined: RS2 shows the old value in that cycle.
- CLR and mid-sweep reset:
  - Fill x1..x31 with nonzero data, pulse CLR: required BUSY=1 for 32 edges, then all reads 0; writes issued while BUSY are lost.
  - Assert RST at cnt=10: required sweep restarts and BUSY stays high for 32 edges after RST falls.
